sum_host_ctrl: RTL and testbench
================================

SUM_HOST_CTRL -- requirements
Module: sum_host_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16: cycles allowed between m_start and m_done.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 cmd_go  in  1  start a job; sampled only in IDLE.
REQ-005 cmd_len  in  3  entry count minus one (0 = 1 entry, 7 = 8 entries).
REQ-006 in_data  in  8  byte to load.
REQ-007 in_valid  in  1  in_data valid.
REQ-008 in_ready  out  1  controller accepts in_data.
REQ-009 m_addr  out  3  memory address to the sum unit.
REQ-010 m_we  out  1  write strobe to the sum unit.
REQ-011 m_din  out  8  write data to the sum unit.
REQ-012 m_re  out  1  read strobe to the sum unit.
REQ-013 m_start  out  1  one-cycle summation start pulse.
REQ-014 m_dout  in  8  read data, valid the cycle after m_re.
REQ-015 m_done  in  1  summation complete.
REQ-016 m_ans  in  8  summation result, valid with m_done.
REQ-017 busy  out  1  job in progress (state not IDLE).
REQ-018 res_valid  out  1  one-cycle result strobe.
REQ-019 res_sum  out  8  m_ans captured at m_done; held until next cmd_go.
REQ-020 err_code  out  2  00 ok, 01 readback mismatch, 10 sum mismatch, 11 timeout; held until next cmd_go.

Function
REQ-021 FSM states: IDLE, LOAD, VERIFY, RUN, WAIT, DONE.
REQ-022 IDLE: when cmd_go=1, latch cmd_len, clear idx, local sum, res_sum and err_code, and enter LOAD next cycle. cmd_go in any other state is ignored.
REQ-023 LOAD: in_ready=1. On each in_valid&in_ready, store the byte in shadow[idx] and add it to the local sum modulo 256. In the following cycle, drive m_we=1, m_addr=idx, m_din=byte.
REQ-024 LOAD handshake: gaps in in_valid insert idle cycles with m_we=0. The handshake at idx==len is the last; after its write the FSM enters VERIFY and in_ready drops.
REQ-025 VERIFY: drive m_re=1 with m_addr=0..len on consecutive cycles. Compare m_dout against shadow one cycle after each read.
REQ-026 VERIFY mismatch: on the first mismatch set err_code=01 and enter DONE. m_start is never issued.
REQ-027 VERIFY pass: after the last compare passes, enter RUN.
REQ-028 RUN: m_start=1 for exactly one cycle, then enter WAIT with the timeout counter cleared.
REQ-029 WAIT, m_done=1: capture res_sum=m_ans. If m_ans differs from the local sum, set err_code=10. Enter DONE.
REQ-030 WAIT timeout: if TIMEOUT cycles elapse without m_done, set err_code=11 and enter DONE. If m_done and the timeout occur in the same cycle, m_done wins.
REQ-031 DONE: res_valid=1 for one cycle, then return to IDLE. busy=0 from the cycle after DONE.
REQ-032 m_we, m_re and m_start are mutually exclusive in every cycle.
REQ-033 m_done outside WAIT is ignored. in_valid outside LOAD is not consumed.
REQ-034 Sums wrap modulo 256. No overflow flag.

Reset
REQ-035 rst=1: state IDLE; all outputs 0, including res_sum, err_code, in_ready and the m_* strobes; idx, counters and local sum cleared.
REQ-036 Reset asserted mid-job aborts the job with no further m_* strobes. A cmd_go after reset release starts a clean job.
REQ-037 Shadow storage contents are not reset; they are always rewritten before being read.

Structure
REQ-038 Package sum_host_pkg holds the state enum, the err_code constants, ADDR_W=3 and DATA_W=8.
REQ-039 The 8x8 shadow store is sub-module sum_host_shadow (one write port, one read port, synchronous write, combinational read).
REQ-040 The FSM, counters and local accumulator live in sum_host_ctrl.

Verification
REQ-041 Sum unit model is used by all scenarios. Stimulus: cmd_len=5, bytes 10,20,30,40,50,60 streamed back-to-back. Required: writes to addr 0..5 on consecutive cycles, six reads, one m_start; model returns 210; res_sum=210, err_code=00.
REQ-042 Stimulus: cmd_len=7, eight bytes of 0xFF. Required: res_sum=0xF8, err_code=00.
REQ-043 Stimulus: model corrupts addr 2 on readback. Required: err_code=01, res_valid pulses, m_start never asserted.
REQ-044 Stimulus: model never asserts m_done. Required: err_code=11 exactly 16 cycles after m_start; res_sum=0.
REQ-045 Stimulus: in_valid with 2-cycle gaps; rst asserted after 3 bytes, then a fresh 1-entry job with byte 7. Required: all outputs 0 during reset; second job gives res_sum=7, err_code=00.
REQ-046 Stimulus: model returns m_ans=99 for the 210 job. Required: res_sum=99, err_code=10.

Source files
------------

// File: rtl/sum_host_pkg.sv
// Shared types and constants for the summation host controller.
package sum_host_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    VERIFY,
    RUN,
    WAIT,
    DONE
  } state_t;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_READBACK = 2'b01;
  localparam logic [1:0] ERR_SUM      = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

endpackage

// File: rtl/sum_host_shadow.sv
// Local copy of the bytes written to the sum unit, used to check readback.
module sum_host_shadow
  import sum_host_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata_c
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_c = mem[raddr];

endmodule

// File: rtl/sum_host_ctrl.sv
// Loads bytes into the sum unit, verifies them by readback, runs the
// summation and checks the returned answer against a local sum.
module sum_host_ctrl
  import sum_host_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_go,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [DATA_W-1:0] m_din,
  output logic              m_re,
  output logic              m_start,
  input  logic [DATA_W-1:0] m_dout,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_ans,
  output logic              busy,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_sum,
  output logic [1:0]        err_code
);

  localparam int unsigned TCNT_W = $clog2(TIMEOUT + 1);

  state_t            state;
  logic [ADDR_W-1:0] len;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] cmp_addr;
  logic              cmp_pend;
  logic              rd_done;
  logic [DATA_W-1:0] sum;
  logic [TCNT_W-1:0] tcnt;
  logic [DATA_W-1:0] shadow_rdata_c;
  logic              load_fire_c;
  logic              timeout_c;

  assign load_fire_c = (state == LOAD) && in_valid && in_ready;
  // err_code becomes visible exactly TIMEOUT cycles after the m_start cycle
  assign timeout_c   = (32'(tcnt) + 32'd2) >= TIMEOUT;

  sum_host_shadow u_shadow (
    .clk     (clk),
    .we      (load_fire_c),
    .waddr   (idx),
    .wdata   (in_data),
    .raddr   (cmp_addr),
    .rdata_c (shadow_rdata_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      len       <= '0;
      idx       <= '0;
      cmp_addr  <= '0;
      cmp_pend  <= 1'b0;
      rd_done   <= 1'b0;
      sum       <= '0;
      tcnt      <= '0;
      in_ready  <= 1'b0;
      m_addr    <= '0;
      m_we      <= 1'b0;
      m_din     <= '0;
      m_re      <= 1'b0;
      m_start   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_sum   <= '0;
      err_code  <= ERR_OK;
    end else begin
      m_we      <= 1'b0;
      m_re      <= 1'b0;
      m_start   <= 1'b0;
      res_valid <= 1'b0;
      // read data returns one cycle after m_re; remember which address it belongs to
      cmp_pend  <= m_re;
      cmp_addr  <= m_addr;

      case (state)
        IDLE: begin
          if (cmd_go) begin
            len      <= cmd_len;
            idx      <= '0;
            sum      <= '0;
            res_sum  <= '0;
            err_code <= ERR_OK;
            in_ready <= 1'b1;
            busy     <= 1'b1;
            state    <= LOAD;
          end
        end

        LOAD: begin
          if (load_fire_c) begin
            m_we   <= 1'b1;
            m_addr <= idx;
            m_din  <= in_data;
            sum    <= sum + in_data;
            idx    <= idx + 1'b1;
            if (idx == len) begin
              in_ready <= 1'b0;
              idx      <= '0;
              rd_done  <= 1'b0;
              state    <= VERIFY;
            end
          end
        end

        VERIFY: begin
          if (cmp_pend && (m_dout != shadow_rdata_c)) begin
            err_code  <= ERR_READBACK;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (cmp_pend && (cmp_addr == len)) begin
            m_start <= 1'b1;
            state   <= RUN;
          end else if (!rd_done) begin
            m_re    <= 1'b1;
            m_addr  <= idx;
            idx     <= idx + 1'b1;
            rd_done <= (idx == len);
          end
        end

        RUN: begin
          tcnt  <= '0;
          state <= WAIT;
        end

        WAIT: begin
          if (m_done) begin
            res_sum   <= m_ans;
            if (m_ans != sum) err_code <= ERR_SUM;
            res_valid <= 1'b1;
            state     <= DONE;
          end else if (timeout_c) begin
            err_code  <= ERR_TIMEOUT;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_host_ctrl.sv
// Bench for sum_host_ctrl: sum-unit model, job table and scoreboard.
module tb_sum_host_ctrl;
  import sum_host_pkg::*;

  typedef struct {
    logic [2:0]      len;
    logic [7:0][7:0] bytes;
    int              gap;
    bit              corrupt;
    bit              no_done;
    bit              ans_ovr;
    logic [7:0]      ans_val;
    logic [7:0]      exp_sum;
    logic [1:0]      exp_err;
    int              exp_rd;
    int              exp_st;
    int              exp_to;
  } job_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_go = 1'b0;
  logic [2:0] cmd_len = '0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] m_addr;
  logic       m_we;
  logic [7:0] m_din;
  logic       m_re;
  logic       m_start;
  logic [7:0] m_dout = '0;
  logic       m_done = 1'b0;
  logic [7:0] m_ans = '0;
  logic       busy;
  logic       res_valid;
  logic [7:0] res_sum;
  logic [1:0] err_code;

  sum_host_ctrl #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .cmd_go(cmd_go), .cmd_len(cmd_len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .m_addr(m_addr), .m_we(m_we), .m_din(m_din), .m_re(m_re),
    .m_start(m_start), .m_dout(m_dout), .m_done(m_done), .m_ans(m_ans),
    .busy(busy), .res_valid(res_valid), .res_sum(res_sum), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   wr_cnt, rd_cnt, st_cnt, rv_cnt, excl_bad;
  int   first_wr, last_wr, start_cyc, err_cyc;
  job_t cur;
  job_t exp_e;
  job_t sb_q[$];
  job_t jobs[6];

  function automatic void chk(string name, longint act, longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic job_t mk(logic [2:0] len, logic [7:0][7:0] bytes, int gap,
                              bit corrupt, bit no_done, bit ans_ovr, logic [7:0] ans_val,
                              logic [7:0] exp_sum, logic [1:0] exp_err,
                              int exp_rd, int exp_st, int exp_to);
    job_t j;
    j.len = len; j.bytes = bytes; j.gap = gap;
    j.corrupt = corrupt; j.no_done = no_done; j.ans_ovr = ans_ovr; j.ans_val = ans_val;
    j.exp_sum = exp_sum; j.exp_err = exp_err;
    j.exp_rd = exp_rd; j.exp_st = exp_st; j.exp_to = exp_to;
    return j;
  endfunction

  // Sum unit model: byte memory, one-cycle read latency, answer a few cycles after m_start
  logic [7:0] mem [8];
  logic       pend = 1'b0;
  int         dly = 0;

  function automatic logic [7:0] model_sum();
    logic [7:0] s = 8'd0;
    for (int a = 0; a <= int'(cur.len); a++) s += mem[a];
    return s;
  endfunction

  always @(posedge clk) begin
    if (m_we) mem[m_addr] <= m_din;
    if (m_re) m_dout <= (cur.corrupt && m_addr == 3'd2) ? (mem[m_addr] ^ 8'h5A) : mem[m_addr];
    m_done <= 1'b0;
    if (rst) pend <= 1'b0;
    else if (m_start && !cur.no_done) begin
      pend <= 1'b1;
      dly  <= 3;
    end else if (pend) begin
      if (dly == 0) begin
        pend   <= 1'b0;
        m_done <= 1'b1;
        m_ans  <= cur.ans_ovr ? cur.ans_val : model_sum();
      end else dly <= dly - 1;
    end
  end

  // Monitor: strobe bookkeeping and scoreboard pop on res_valid
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (int'(m_we) + int'(m_re) + int'(m_start) > 1) excl_bad++;
      if (m_we) begin
        chk("wr_addr", m_addr, wr_cnt);
        chk("wr_data", m_din, cur.bytes[m_addr]);
        if (wr_cnt == 0) first_wr = cyc;
        last_wr = cyc;
        wr_cnt++;
      end
      if (m_re) rd_cnt++;
      if (m_start) begin
        st_cnt++;
        start_cyc = cyc;
      end
      if (err_code == 2'b11 && err_cyc < 0) err_cyc = cyc;
      if (res_valid) begin
        rv_cnt++;
        if (sb_q.size() == 0) chk("res_valid_unexpected", 1, 0);
        else begin
          exp_e = sb_q.pop_front();
          chk("res_sum", res_sum, exp_e.exp_sum);
          chk("err_code", err_code, exp_e.exp_err);
        end
      end
    end
  end

  function automatic longint out_vec();
    return longint'({in_ready, m_addr, m_we, m_din, m_re, m_start,
                     busy, res_valid, res_sum, err_code});
  endfunction

  task automatic clear_counts();
    wr_cnt = 0; rd_cnt = 0; st_cnt = 0; rv_cnt = 0; excl_bad = 0;
    first_wr = -1; last_wr = -1; start_cyc = -1; err_cyc = -1;
  endtask

  task automatic feed(input job_t j, input int n);
    int g;
    for (int b = 0; b < n; b++) begin
      repeat (j.gap) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = j.bytes[b];
      g = 0;
      while (!in_ready && g < 50) begin
        @(negedge clk);
        g++;
      end
      if (!in_ready) begin
        chk("in_ready_wait", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic start_job(input job_t j);
    cur = j;
    clear_counts();
    cmd_len = j.len;
    cmd_go  = 1'b1;
    @(negedge clk);
    cmd_go  = 1'b0;
  endtask

  task automatic run_job(input job_t j);
    int g;
    sb_q.push_back(j);
    start_job(j);
    feed(j, int'(j.len) + 1);
    g = 0;
    while (sb_q.size() != 0 && g < 300) begin
      @(negedge clk);
      g++;
    end
    chk("job_done", sb_q.size(), 0);
    sb_q.delete();
    @(negedge clk);
    @(negedge clk);
    chk("busy_after", busy, 0);
    chk("res_valid_pulses", rv_cnt, 1);
    chk("write_count", wr_cnt, int'(j.len) + 1);
    chk("write_span", last_wr - first_wr, int'(j.len) * (j.gap + 1));
    if (j.exp_rd >= 0) chk("read_count", rd_cnt, j.exp_rd);
    chk("start_count", st_cnt, j.exp_st);
    chk("strobe_exclusive", excl_bad, 0);
    if (j.exp_to >= 0) chk("timeout_latency", err_cyc - start_cyc, j.exp_to);
  endtask

  initial begin
    job_t ab;
    jobs[0] = mk(3'd5, {8'd0, 8'd0, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0,
                 0, 0, 0, 8'd0, 8'd210, 2'b00, 6, 1, -1);
    jobs[1] = mk(3'd7, {8{8'hFF}}, 0, 0, 0, 0, 8'd0, 8'hF8, 2'b00, 8, 1, -1);
    jobs[2] = mk(3'd5, {8'd0, 8'd0, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0,
                 1, 0, 0, 8'd0, 8'd0, 2'b01, -1, 0, -1);
    jobs[3] = mk(3'd5, {8'd0, 8'd0, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0,
                 0, 1, 0, 8'd0, 8'd0, 2'b11, 6, 1, 16);
    jobs[4] = mk(3'd5, {8'd0, 8'd0, 8'd60, 8'd50, 8'd40, 8'd30, 8'd20, 8'd10}, 0,
                 0, 0, 1, 8'd99, 8'd99, 2'b10, 6, 1, -1);
    jobs[5] = mk(3'd3, {8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd7, 8'd100, 8'd200}, 1,
                 0, 0, 0, 8'd0, 8'd52, 2'b00, 4, 1, -1);
    cur = jobs[0];
    clear_counts();

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs", out_vec(), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_outputs", out_vec(), 0);

    for (int i = 0; i < 6; i++) run_job(jobs[i]);

    // Reset in the middle of a gapped load, then a fresh single-entry job
    ab = mk(3'd7, {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, 2,
            0, 0, 0, 8'd0, 8'd0, 2'b00, -1, 0, -1);
    start_job(ab);
    feed(ab, 3);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("outputs_in_reset", out_vec(), 0);
      @(negedge clk);
    end
    clear_counts();
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_strobes", wr_cnt + rd_cnt + st_cnt, 0);
    chk("abort_busy", busy, 0);
    run_job(mk(3'd0, {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd7}, 2,
               0, 0, 0, 8'd0, 8'd7, 2'b00, 1, 1, -1));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
